// File: rtl/interrupt_controller_if.sv
// Processor-side handshake of the interrupt controller: the held request line,
// the id/vector of the source being requested, and the ack/eoi pulses from the core.
interface interrupt_controller_if #(
  parameter int ID_W = 2
) ();
  logic            interupt;
  logic [ID_W-1:0] int_id;
  logic [15:0]     int_vector;
  logic            int_ack;
  logic            int_eoi;

  // Controller side drives the request, the processor side answers it.
  modport master (output interupt, int_id, int_vector, input  int_ack, int_eoi);
  modport slave  (input  interupt, int_id, int_vector, output int_ack, int_eoi);
endinterface

// File: rtl/interrupt_controller.sv
// Prioritised interrupt front-end: synchronises and edge-detects external
// sources, latches pending events, applies a mask and hands the lowest
// eligible source to the processor with a held request until ack, then
// blocks further requests until end-of-interrupt.
module interrupt_controller #(
  parameter int                 NUM_SRC  = 4,
  parameter int                 ID_W     = 2,
  parameter logic [15:0]        VEC_BASE = 16'h0000,
  parameter logic [NUM_SRC-1:0] MASK_RST = '1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_data,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask,
  interrupt_controller_if.master cpu
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [15:0]        vec_q, vec_d;
  logic [NUM_SRC-1:0] sync1_q, sync2_q, sync3_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] edge_det, eligible, clr;
  logic [ID_W-1:0]    sel_id;

  // A rising edge is sync2 freshly high while sync3 still holds the old level.
  assign edge_det = sync2_q & ~sync3_q;
  assign eligible = pending_q & mask_q;

  // Input path: two-flop synchroniser plus an edge-detect stage per source.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= irq_src;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Lowest eligible index wins; index 0 has the highest priority.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    sel_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) sel_id = ID_W'(i);
    end
  end

  // Request FSM next-state, plus the pending-clear produced by an accepted ack.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    vec_d   = vec_q;
    clr     = '0;
    unique case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d = REQ;
          id_d    = sel_id;
          vec_d   = VEC_BASE + 16'(sel_id);
        end
      end
      REQ: begin
        // The latched id is committed: no preemption, no cancel by masking.
        if (cpu.int_ack) begin
          state_d = SERVICE;
          clr[id_q] = 1'b1;
        end
      end
      SERVICE: begin
        if (cpu.int_eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A new edge on the source being cleared wins over the clear.
  assign pending_d = (pending_q & ~clr) | edge_det;
  assign mask_d    = mask_we ? mask_data : mask_q;

  // State, latched id/vector, pending events and mask register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      id_q      <= '0;
      vec_q     <= VEC_BASE;
      pending_q <= '0;
      mask_q    <= MASK_RST;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      vec_q     <= vec_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

  // The request is a decode of the registered state, so it is glitch-free.
  assign cpu.interupt   = (state_q == REQ);
  assign cpu.int_id     = id_q;
  assign cpu.int_vector = vec_q;
  assign pending        = pending_q;
  assign mask           = mask_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: a linear stimulus sequence with
// direct checks, plus a monitor that pops the expected source id from a
// scoreboard queue each time a new request rises.
module tb_interrupt_controller;

  localparam int          NUM_SRC = 4;
  localparam int          ID_W    = 2;
  localparam logic [15:0] VB      = 16'h0010;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [NUM_SRC-1:0] irq_src = '0;
  logic               mask_we = 1'b0;
  logic [NUM_SRC-1:0] mask_data = '0;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] mask;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [ID_W-1:0] exp_q[$];
  logic            irq_prev = 1'b0;

  interrupt_controller_if #(.ID_W(ID_W)) cpu_if ();

  interrupt_controller #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W),
    .VEC_BASE(VB),
    .MASK_RST(4'b1111)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .irq_src  (irq_src),
    .mask_we  (mask_we),
    .mask_data(mask_data),
    .pending  (pending),
    .mask     (mask),
    .cpu      (cpu_if.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    cpu_if.int_ack = 1'b1;
    step(1);
    cpu_if.int_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    cpu_if.int_eoi = 1'b1;
    step(1);
    cpu_if.int_eoi = 1'b0;
  endtask

  // Scoreboard: every new request must match the oldest expected id.
  always @(negedge clk) begin
    if (reset && cpu_if.interupt && !irq_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_request", {30'd0, cpu_if.int_id}, 32'hFFFF_FFFF);
      end else begin
        logic [ID_W-1:0] e;
        e = exp_q.pop_front();
        check("sb_id", {30'd0, cpu_if.int_id}, {30'd0, e});
        check("sb_vec", {16'd0, cpu_if.int_vector}, {16'd0, 16'(VB + 16'(e))});
      end
    end
    irq_prev <= cpu_if.interupt;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    cpu_if.int_ack = 1'b0;
    cpu_if.int_eoi = 1'b0;

    // Reset values
    step(3);
    check("rst_interupt", {31'd0, cpu_if.interupt}, 32'd0);
    check("rst_id", {30'd0, cpu_if.int_id}, 32'd0);
    check("rst_vec", {16'd0, cpu_if.int_vector}, {16'd0, VB});
    check("rst_pending", {28'd0, pending}, 32'd0);
    check("rst_mask", {28'd0, mask}, 32'hF);
    reset = 1'b1;
    step(2);

    // Single source, 3-edge latency to pending, request one edge later
    exp_q.push_back(2'd2);
    irq_src = 4'b0100;
    step(1);
    irq_src = '0;
    step(1);
    check("single_pend_early", {28'd0, pending}, 32'd0);
    step(1);
    check("single_pend", {28'd0, pending}, 32'h4);
    check("single_no_req_yet", {31'd0, cpu_if.interupt}, 32'd0);
    step(1);
    check("single_req", {31'd0, cpu_if.interupt}, 32'd1);
    check("single_id", {30'd0, cpu_if.int_id}, 32'd2);
    check("single_vec", {16'd0, cpu_if.int_vector}, 32'h12);
    pulse_ack();
    check("single_ack_req", {31'd0, cpu_if.interupt}, 32'd0);
    check("single_ack_pend", {28'd0, pending}, 32'd0);
    check("single_svc_id", {30'd0, cpu_if.int_id}, 32'd2);
    pulse_eoi();
    check("single_idle", {31'd0, cpu_if.interupt}, 32'd0);

    // Priority and queueing
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd3);
    irq_src = 4'b1010;
    step(1);
    irq_src = '0;
    step(2);
    check("prio_pend", {28'd0, pending}, 32'hA);
    step(1);
    check("prio_first_id", {30'd0, cpu_if.int_id}, 32'd1);
    check("prio_first_vec", {16'd0, cpu_if.int_vector}, 32'h11);
    pulse_ack();
    check("prio_after_ack_pend", {28'd0, pending}, 32'h8);
    check("prio_after_ack_req", {31'd0, cpu_if.interupt}, 32'd0);
    pulse_eoi();
    check("prio_idle_gap", {31'd0, cpu_if.interupt}, 32'd0);
    step(1);
    check("prio_second_req", {31'd0, cpu_if.interupt}, 32'd1);
    check("prio_second_id", {30'd0, cpu_if.int_id}, 32'd3);
    pulse_ack();
    pulse_eoi();

    // Masking: masked source latches but does not request
    mask_we = 1'b1;
    mask_data = 4'b1110;
    step(1);
    mask_we = 1'b0;
    check("mask_write", {28'd0, mask}, 32'hE);
    irq_src = 4'b0001;
    step(1);
    irq_src = '0;
    step(5);
    check("mask_pend", {28'd0, pending}, 32'h1);
    check("mask_no_req", {31'd0, cpu_if.interupt}, 32'd0);
    exp_q.push_back(2'd0);
    mask_we = 1'b1;
    mask_data = 4'b1111;
    step(1);
    mask_we = 1'b0;
    check("unmask_value", {28'd0, mask}, 32'hF);
    check("unmask_not_yet", {31'd0, cpu_if.interupt}, 32'd0);
    step(1);
    check("unmask_req", {31'd0, cpu_if.interupt}, 32'd1);
    check("unmask_id", {30'd0, cpu_if.int_id}, 32'd0);
    pulse_ack();
    pulse_eoi();

    // Level hold gives one request; retrigger coinciding with ack is kept
    exp_q.push_back(2'd1);
    irq_src = 4'b0010;
    step(10);
    irq_src = '0;
    check("hold_req", {31'd0, cpu_if.interupt}, 32'd1);
    check("hold_id", {30'd0, cpu_if.int_id}, 32'd1);
    step(3);
    exp_q.push_back(2'd1);
    irq_src = 4'b0010;
    step(1);
    irq_src = '0;
    step(1);
    cpu_if.int_ack = 1'b1;
    step(1);
    cpu_if.int_ack = 1'b0;
    check("merge_pend", {28'd0, pending}, 32'h2);
    check("merge_req_low", {31'd0, cpu_if.interupt}, 32'd0);
    pulse_eoi();
    step(1);
    check("merge_second_req", {31'd0, cpu_if.interupt}, 32'd1);
    check("merge_second_id", {30'd0, cpu_if.int_id}, 32'd1);
    pulse_ack();
    pulse_eoi();

    // Simultaneous ack and eoi in REQ: only the ack is taken
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    irq_src = 4'b0011;
    step(1);
    irq_src = '0;
    step(3);
    check("both_req_id", {30'd0, cpu_if.int_id}, 32'd0);
    cpu_if.int_ack = 1'b1;
    cpu_if.int_eoi = 1'b1;
    step(1);
    cpu_if.int_ack = 1'b0;
    cpu_if.int_eoi = 1'b0;
    check("both_pend", {28'd0, pending}, 32'h2);
    step(2);
    check("both_still_service", {31'd0, cpu_if.interupt}, 32'd0);
    pulse_eoi();
    step(1);
    check("both_next_id", {30'd0, cpu_if.int_id}, 32'd1);
    pulse_ack();

    // Reset asserted during SERVICE with an event pending
    irq_src = 4'b0100;
    step(1);
    irq_src = '0;
    step(4);
    check("svc_accumulate", {28'd0, pending}, 32'h4);
    check("svc_no_req", {31'd0, cpu_if.interupt}, 32'd0);
    reset = 1'b0;
    #2;
    check("midrst_pend", {28'd0, pending}, 32'd0);
    check("midrst_req", {31'd0, cpu_if.interupt}, 32'd0);
    check("midrst_id", {30'd0, cpu_if.int_id}, 32'd0);
    check("midrst_vec", {16'd0, cpu_if.int_vector}, {16'd0, VB});
    step(2);
    reset = 1'b1;
    step(1);
    pulse_eoi();
    step(3);
    check("post_eoi_req", {31'd0, cpu_if.interupt}, 32'd0);
    check("post_eoi_pend", {28'd0, pending}, 32'd0);

    check("sb_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
